// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcodes, branch condition codes, flag bit positions, flag/branch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_RED    = 3'b010,
    ALU_XOR    = 3'b011,
    ALU_SLL    = 3'b100,
    ALU_SRA    = 3'b101,
    ALU_ROR    = 3'b110,
    ALU_PADDSB = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    COND_NE  = 3'b000,
    COND_EQ  = 3'b001,
    COND_GT  = 3'b010,
    COND_LT  = 3'b011,
    COND_GE  = 3'b100,
    COND_LE  = 3'b101,
    COND_OVF = 3'b110,
    COND_AL  = 3'b111
  } cond_e;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    FBU_IDLE     = 2'b00,
    FBU_HOLD     = 2'b01,
    FBU_REDIRECT = 2'b10
  } fbu_state_e;

  // ADD/SUB update N, Z and V.
  function automatic logic op_writes_nv(alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // Every op except RED and PADDSB updates Z.
  function automatic logic op_writes_z(alu_op_e op);
    return (op != ALU_RED) && (op != ALU_PADDSB);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: maps a 3-bit condition code and {N,Z,V} to taken/not-taken.
// Latency: purely combinational.
// Backpressure: none.
module br_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       true
);

  logic n;
  logic z;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  // Decode the condition code against the supplied flags.
  always_comb begin
    true = 1'b0;
    case (cond_e'(cond))
      COND_NE:  true = ~z;
      COND_EQ:  true = z;
      COND_GT:  true = ~z & ~n;
      COND_LT:  true = n;
      COND_GE:  true = z | ~n;
      COND_LE:  true = n | z;
      COND_OVF: true = v;
      COND_AL:  true = 1'b1;
      default:  true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register plus conditional-branch resolver producing a one-cycle redirect pulse.
// Latency: one cycle from an accepted branch in ID to br_taken/br_target.
// Backpressure: stall freezes flags and FSM (REDIRECT still retires); br_hazard asks ID to re-present.
module flag_branch_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [2:0]  ex_ctl,
  input  logic [2:0]  alu_flags,
  input  logic        id_valid,
  input  logic        id_br,
  input  logic        id_brr,
  input  logic [2:0]  id_cond,
  input  logic [8:0]  id_imm9,
  input  logic [15:0] id_pc_plus2,
  input  logic [15:0] id_rs_data,
  output logic [2:0]  flags_q,
  output logic        br_hazard,
  output logic        br_taken,
  output logic [15:0] br_target,
  output logic        br_flush
);

  alu_op_e    ex_op;
  logic       flag_we;
  logic       ex_writes_flags;
  logic       br_req;
  logic       cond_true;
  logic [15:0] target_calc;
  logic       load_target;
  logic       taken_q;
  logic [15:0] target_q;
  fbu_state_e state_q;
  fbu_state_e state_d;

  assign ex_op   = alu_op_e'(ex_ctl);
  assign flag_we = ex_valid & ~stall;

  // Any op that writes Z also covers the N/V writers, so it marks a flag producer.
  assign ex_writes_flags = ex_valid & op_writes_z(ex_op);

  assign br_req    = id_valid & (id_br | id_brr) & ~stall & ~br_flush;
  assign br_hazard = br_req & ex_writes_flags;

  // Conditions always see the registered flags, never the in-flight ALU result.
  br_cond_eval u_cond (
    .cond  (id_cond),
    .flags (flags_q),
    .true  (cond_true)
  );

  // BR wins when both branch kinds are flagged; B offset is a signed word count.
  assign target_calc = id_brr ? id_rs_data
                              : id_pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};

  // Architectural flag register: per-bit write enables by ALU op, unwritten bits hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (flag_we) begin
      if (op_writes_nv(ex_op)) begin
        flags_q[FLAG_N] <= alu_flags[FLAG_N];
        flags_q[FLAG_V] <= alu_flags[FLAG_V];
      end
      if (op_writes_z(ex_op)) begin
        flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
      end
    end
  end

  // State register for the branch FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FBU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. HOLD is the cycle in which the re-presented branch sees the
  // producer's flags, so it resolves the request itself and otherwise falls back to IDLE.
  // A stalled cycle cannot carry a request, so IDLE/HOLD simply keep their state then.
  always_comb begin
    state_d     = state_q;
    load_target = 1'b0;
    case (state_q)
      FBU_IDLE, FBU_HOLD: begin
        if (br_hazard) begin
          state_d = FBU_HOLD;
        end else if (br_req && cond_true) begin
          state_d     = FBU_REDIRECT;
          load_target = 1'b1;
        end else if (!stall) begin
          state_d = FBU_IDLE;
        end
      end
      FBU_REDIRECT: state_d = FBU_IDLE;
      default:      state_d = FBU_IDLE;
    endcase
  end

  // Registered redirect pulse and target, so both are flop outputs in REDIRECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q  <= 1'b0;
      target_q <= 16'h0000;
    end else begin
      taken_q <= (state_d == FBU_REDIRECT);
      if (load_target) begin
        target_q <= target_calc;
      end
    end
  end

  assign br_taken  = taken_q;
  assign br_flush  = taken_q;
  assign br_target = target_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ex_valid;
  logic [2:0]  ex_ctl;
  logic [2:0]  alu_flags;
  logic        id_valid;
  logic        id_br;
  logic        id_brr;
  logic [2:0]  id_cond;
  logic [8:0]  id_imm9;
  logic [15:0] id_pc_plus2;
  logic [15:0] id_rs_data;
  logic [2:0]  flags_q;
  logic        br_hazard;
  logic        br_taken;
  logic [15:0] br_target;
  logic        br_flush;

  logic [2:0]  ref_cond;
  logic [2:0]  ref_flags;
  logic        ref_true;

  int nvec = 0;
  int nmis = 0;

  flag_branch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_ctl      (ex_ctl),
    .alu_flags   (alu_flags),
    .id_valid    (id_valid),
    .id_br       (id_br),
    .id_brr      (id_brr),
    .id_cond     (id_cond),
    .id_imm9     (id_imm9),
    .id_pc_plus2 (id_pc_plus2),
    .id_rs_data  (id_rs_data),
    .flags_q     (flags_q),
    .br_hazard   (br_hazard),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .br_flush    (br_flush)
  );

  br_cond_eval u_ref (
    .cond  (ref_cond),
    .flags (ref_flags),
    .true  (ref_true)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-written truth table for the condition codes ({N,Z,V}).
  function automatic logic exp_cond(input logic [2:0] c, input logic [2:0] f);
    logic n;
    logic z;
    logic v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic clr_in();
    stall       = 1'b0;
    ex_valid    = 1'b0;
    ex_ctl      = 3'b000;
    alu_flags   = 3'b000;
    id_valid    = 1'b0;
    id_br       = 1'b0;
    id_brr      = 1'b0;
    id_cond     = 3'b000;
    id_imm9     = 9'h000;
    id_pc_plus2 = 16'h0000;
    id_rs_data  = 16'h0000;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [2:0] op, input logic [2:0] f);
    ex_valid  = 1'b1;
    ex_ctl    = op;
    alu_flags = f;
  endtask

  task automatic set_b(input logic [2:0] c, input logic [8:0] imm, input logic [15:0] pc);
    id_valid    = 1'b1;
    id_br       = 1'b1;
    id_brr      = 1'b0;
    id_cond     = c;
    id_imm9     = imm;
    id_pc_plus2 = pc;
  endtask

  // A flag-writing EX op and an unhazarded ID branch request must never coincide.
  always @(negedge clk) begin
    #2;
    if (rst_n && ex_valid && !stall && (ex_ctl != 3'b010) && (ex_ctl != 3'b111) &&
        id_valid && (id_br || id_brr) && !br_flush) begin
      chk("fw_with_branch_needs_hazard", {15'd0, br_hazard}, 16'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    ref_cond  = 3'd0;
    ref_flags = 3'd0;
    rst_n     = 1'b0;
    #3;
    chk("rst_flags", {13'd0, flags_q}, 16'h0000);
    chk("rst_taken", {15'd0, br_taken}, 16'h0000);
    chk("rst_flush", {15'd0, br_flush}, 16'h0000);
    chk("rst_target", br_target, 16'h0000);

    // First edge after deassertion performs ADD flag write, then async reset mid-cycle.
    @(negedge clk);
    rst_n = 1'b1;
    set_ex(3'b000, 3'b111);
    cyc();
    chk("add_first_edge", {13'd0, flags_q}, 16'h0007);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midcyc_rst_flags", {13'd0, flags_q}, 16'h0000);
    chk("midcyc_rst_taken", {15'd0, br_taken}, 16'h0000);
    clr_in();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Partial flag writes.
    set_ex(3'b001, 3'b001);
    cyc();
    chk("sub_001", {13'd0, flags_q}, 16'h0001);
    set_ex(3'b011, 3'b101);
    cyc();
    chk("xor_z_only", {13'd0, flags_q}, 16'h0001);
    set_ex(3'b101, 3'b110);
    cyc();
    chk("sra_z_set", {13'd0, flags_q}, 16'h0003);
    set_ex(3'b010, 3'b100);
    cyc();
    chk("red_no_write", {13'd0, flags_q}, 16'h0003);
    set_ex(3'b111, 3'b000);
    cyc();
    chk("paddsb_no_write", {13'd0, flags_q}, 16'h0003);

    // SUB -> Z only, then B EQ with negative offset.
    set_ex(3'b001, 3'b010);
    cyc();
    chk("sub_010", {13'd0, flags_q}, 16'h0002);
    clr_in();
    set_b(3'b001, 9'h1FE, 16'h0010);
    #1;
    chk("beq_no_hazard", {15'd0, br_hazard}, 16'h0000);
    cyc();
    clr_in();
    chk("beq_taken", {15'd0, br_taken}, 16'h0001);
    chk("beq_flush", {15'd0, br_flush}, 16'h0001);
    chk("beq_target", br_target, 16'h000C);
    cyc();
    chk("beq_taken_drop", {15'd0, br_taken}, 16'h0000);
    chk("beq_flush_drop", {15'd0, br_flush}, 16'h0000);

    // False condition: NE with Z=1 stays idle.
    set_b(3'b000, 9'h004, 16'h0040);
    cyc();
    clr_in();
    chk("bne_false", {15'd0, br_taken}, 16'h0000);

    // RED in EX does not cause a hazard.
    set_ex(3'b010, 3'b000);
    set_b(3'b000, 9'h004, 16'h0040);
    #1;
    chk("red_no_hazard", {15'd0, br_hazard}, 16'h0000);
    clr_in();
    cyc();

    // B GT behind an ADD: hazard, HOLD, then resolve with ADD's flags (000 -> GT true).
    set_ex(3'b000, 3'b000);
    set_b(3'b010, 9'h003, 16'h0100);
    #1;
    chk("bgt_hazard", {15'd0, br_hazard}, 16'h0001);
    cyc();
    chk("hold_no_taken", {15'd0, br_taken}, 16'h0000);
    chk("hold_flags", {13'd0, flags_q}, 16'h0000);
    ex_valid = 1'b0;
    #1;
    chk("represent_no_hazard", {15'd0, br_hazard}, 16'h0000);
    cyc();
    clr_in();
    chk("bgt_taken", {15'd0, br_taken}, 16'h0001);
    chk("bgt_target", br_target, 16'h0106);
    cyc();
    chk("bgt_done", {15'd0, br_taken}, 16'h0000);

    // BR always under stall (both id_br and id_brr set), with a frozen ADD in EX.
    id_valid    = 1'b1;
    id_br       = 1'b1;
    id_brr      = 1'b1;
    id_cond     = 3'b111;
    id_imm9     = 9'h005;
    id_pc_plus2 = 16'h2000;
    id_rs_data  = 16'hBEEF;
    stall       = 1'b1;
    set_ex(3'b000, 3'b111);
    #1;
    chk("br_stall_hazard", {15'd0, br_hazard}, 16'h0000);
    cyc();
    chk("br_stall_no_taken", {15'd0, br_taken}, 16'h0000);
    chk("stall_flags_hold", {13'd0, flags_q}, 16'h0000);
    stall    = 1'b0;
    ex_valid = 1'b0;
    cyc();
    clr_in();
    chk("br_taken", {15'd0, br_taken}, 16'h0001);
    chk("br_target", br_target, 16'hBEEF);
    cyc();
    chk("br_done", {15'd0, br_taken}, 16'h0000);

    // Wrap-around target.
    set_b(3'b111, 9'h001, 16'hFFFE);
    cyc();
    clr_in();
    chk("wrap_taken", {15'd0, br_taken}, 16'h0001);
    chk("wrap_target", br_target, 16'h0000);
    stall = 1'b1;
    cyc();
    chk("redirect_exits_on_stall", {15'd0, br_taken}, 16'h0000);
    chk("target_held_stall", br_target, 16'h0000);
    clr_in();
    cyc();

    // Reset during HOLD aborts the branch.
    set_ex(3'b001, 3'b000);
    set_b(3'b111, 9'h010, 16'h0300);
    cyc();
    chk("hold_entry", {15'd0, br_taken}, 16'h0000);
    clr_in();
    #2;
    rst_n = 1'b0;
    #1;
    chk("hold_rst_taken", {15'd0, br_taken}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("hold_abort1", {15'd0, br_taken}, 16'h0000);
    cyc();
    chk("hold_abort2", {15'd0, br_taken}, 16'h0000);

    // Reset during REDIRECT clears the pulse and target.
    set_b(3'b111, 9'h002, 16'h0500);
    cyc();
    clr_in();
    chk("redir_taken", {15'd0, br_taken}, 16'h0001);
    chk("redir_target", br_target, 16'h0504);
    #1;
    rst_n = 1'b0;
    #1;
    chk("redir_rst_taken", {15'd0, br_taken}, 16'h0000);
    chk("redir_rst_target", br_target, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("redir_abort", {15'd0, br_taken}, 16'h0000);

    // Condition evaluator sweep against the hand truth table.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        ref_cond  = c[2:0];
        ref_flags = f[2:0];
        #1;
        chk($sformatf("cond_c%0d_f%0d", c, f), {15'd0, ref_true}, {15'd0, exp_cond(c[2:0], f[2:0])});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
